// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine that feeds the Hi/Lo register file.
// Optional feature macro MDU_FAST_MULT_EN selects a single-cycle multiplier; divides are unaffected.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] write_hi,
  output logic [WIDTH-1:0] write_lo,
  output logic             ld_hi,
  output logic             ld_lo,
  output logic             busy,
  output logic             done
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    neg_2w = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r, mag_b_r;
  logic             is_div_r, neg_res_r, neg_rem_r;
  logic             sign_a_s, sign_b_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s, fin_hi_s, fin_lo_s;
  logic [2*WIDTH-1:0] prod_neg_s;
`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod_s;
  assign fast_prod_s = {ZERO_W, mag_a_s} * {ZERO_W, mag_b_s};
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
`ifdef MDU_FAST_MULT_EN
          if (op[1]) state_s = RUN;
          else       state_s = DONE;
`else
          state_s = RUN;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_ZERO) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand sign extraction and magnitudes (op[0]=0 means signed)
  always_comb begin
    sign_a_s = ~op[0] & A[WIDTH-1];
    sign_b_s = ~op[0] & B[WIDTH-1];
    if (sign_a_s) mag_a_s = neg_w(A);
    else          mag_a_s = A;
    if (sign_b_s) mag_b_s = neg_w(B);
    else          mag_b_s = B;
  end

  // One iteration: shift-add for multiply, restore-subtract for divide
  always_comb begin
    if (lo_r[0]) mul_sum_s = {1'b0, hi_r} + {1'b0, mag_b_r};
    else         mul_sum_s = {1'b0, hi_r};
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, mag_b_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - mag_b_r;
    if (is_div_r) begin
      if (div_ge_s) step_hi_s = div_diff_s;
      else          step_hi_s = div_shift_s[WIDTH-1:0];
      step_lo_s = {lo_r[WIDTH-2:0], div_ge_s};
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up; a zero divisor keeps the all-ones quotient regardless of signs
  always_comb begin
    prod_neg_s = neg_2w({hi_r, lo_r});
    if (is_div_r) begin
      if (neg_res_r && (mag_b_r != ZERO_W)) fin_lo_s = neg_w(lo_r);
      else                                  fin_lo_s = lo_r;
      if (neg_rem_r) fin_hi_s = neg_w(hi_r);
      else           fin_hi_s = hi_r;
    end else if (neg_res_r) begin
      fin_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_neg_s[WIDTH-1:0];
    end else begin
      fin_hi_s = hi_r;
      fin_lo_s = lo_r;
    end
  end

  // Datapath: capture on accept, iterate in RUN, hold otherwise
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_r     <= CNT_ZERO;
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      mag_b_r   <= ZERO_W;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r     <= CNT_LOAD;
            mag_b_r   <= mag_b_s;
            is_div_r  <= op[1];
            neg_res_r <= sign_a_s ^ sign_b_s;
            neg_rem_r <= sign_a_s;
`ifdef MDU_FAST_MULT_EN
            if (op[1]) begin
              hi_r <= ZERO_W;
              lo_r <= mag_a_s;
            end else begin
              hi_r <= fast_prod_s[2*WIDTH-1:WIDTH];
              lo_r <= fast_prod_s[WIDTH-1:0];
            end
`else
            hi_r <= ZERO_W;
            lo_r <= mag_a_s;
`endif
          end
        end
        RUN: begin
          hi_r <= step_hi_s;
          lo_r <= step_lo_s;
          if (cnt_r != CNT_ZERO) cnt_r <= cnt_r - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs; results leave DONE together with the load strobes
  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      ld_hi    <= 1'b0;
      ld_lo    <= 1'b0;
      write_hi <= ZERO_W;
      write_lo <= ZERO_W;
    end else begin
      busy  <= (state_s != IDLE);
      done  <= (state_r == DONE);
      ld_hi <= (state_r == DONE);
      ld_lo <= (state_r == DONE);
      if (state_r == DONE) begin
        write_hi <= fin_hi_s;
        write_lo <= fin_lo_s;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors plus an arithmetic reference model compared every cycle.
module tb_mult_div_unit;
  localparam int W       = 32;
  localparam int LAT_DIV = 33;
`ifdef MDU_FAST_MULT_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif

  logic         Clk, Rst, start;
  logic [1:0]   op;
  logic [W-1:0] A, B, write_hi, write_lo;
  logic         ld_hi, ld_lo, busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit model_on = 1'b0;

  bit          pending = 1'b0;
  bit          exp_pulse = 1'b0;
  bit          exp_busy = 1'b0;
  int          pulse_edge = 0;
  int          busy_until = 0;
  int          next_free = 0;
  logic [63:0] pend_res = 64'd0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .op(op), .A(A), .B(B),
    .write_hi(write_hi), .write_lo(write_lo), .ld_hi(ld_hi), .ld_lo(ld_lo),
    .busy(busy), .done(done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference result as {Hi, Lo} from plain integer arithmetic
  function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Model: which edge accepts, when the pulse lands, what Hi/Lo hold
  always @(posedge Clk) begin : model
    int          e, lat;
    bit          pend_n, pulse_n, busy_n;
    int          pe_n, bu_n, nf_n;
    logic [31:0] hi_n, lo_n;
    logic [63:0] r_n;
    e = cyc + 1;
    pend_n = pending; pulse_n = 1'b0; pe_n = pulse_edge; bu_n = busy_until;
    nf_n = next_free; hi_n = exp_hi; lo_n = exp_lo; r_n = pend_res;
    if (Rst) begin
      pend_n = 1'b0; hi_n = 32'd0; lo_n = 32'd0; nf_n = 0;
    end else begin
      if (pend_n && e == pe_n) begin
        pulse_n = 1'b1;
        hi_n = r_n[63:32];
        lo_n = r_n[31:0];
        pend_n = 1'b0;
      end
      if (!pend_n && e >= nf_n && start) begin
        lat = op[1] ? LAT_DIV : LAT_MUL;
        r_n = model_res(op, A, B);
        pend_n = 1'b1;
        pe_n = e + lat;
        bu_n = e + lat - 1;
        nf_n = e + lat + 1;
      end
    end
    busy_n = pend_n && (e <= bu_n);
    cyc <= e;
    pending <= pend_n; exp_pulse <= pulse_n; exp_busy <= busy_n;
    pulse_edge <= pe_n; busy_until <= bu_n; next_free <= nf_n;
    exp_hi <= hi_n; exp_lo <= lo_n; pend_res <= r_n;
    model_on <= model_on | Rst;
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin
    if (model_on) begin
      check("done", 64'(done), 64'(exp_pulse));
      check("ld_hi", 64'(ld_hi), 64'(exp_pulse));
      check("ld_lo", 64'(ld_lo), 64'(exp_pulse));
      check("busy", 64'(busy), 64'(exp_busy));
      check("write_hi", 64'(write_hi), 64'(exp_hi));
      check("write_lo", 64'(write_lo), 64'(exp_lo));
    end
  end

  task automatic wait_done(input string name, output bit ok);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge Clk);
      n++;
    end
    ok = done;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, n);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int elat);
    int t0;
    bit ok;
    @(negedge Clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge Clk);
    start = 1'b0;
    t0 = cyc;
    wait_done(name, ok);
    if (ok) begin
      check({name, "_lat"}, 64'(cyc - t0), 64'(elat));
      check({name, "_hi"}, 64'(write_hi), 64'(eh));
      check({name, "_lo"}, 64'(write_lo), 64'(el));
    end
  endtask

  initial begin
    int t0, t1, ndone, nlow, nld;
    bit ok;
    Rst = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_write_hi", 64'(write_hi), 64'd0);
    Rst = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT_MUL);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_MUL);
    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, LAT_MUL);
    run_op("mult_min1", 2'b00, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, LAT_MUL);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, LAT_DIV);
    run_op("divu_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, LAT_DIV);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, LAT_DIV);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, LAT_DIV);

    // Extra starts during a DIV must be ignored
    @(negedge Clk);
    start = 1'b1; op = 2'b10; A = 32'd1000; B = 32'd3;
    @(negedge Clk);
    start = 1'b0;
    t0 = cyc; ndone = 0; nlow = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge Clk);
      if (done) begin
        ndone++;
        check("ign_hi", 64'(write_hi), 64'd1);
        check("ign_lo", 64'(write_lo), 64'd333);
      end else if (ndone == 0 && !busy) begin
        nlow++;
      end
      start = (k == 5 || k == 10);
      if (start) begin
        op = 2'b11; A = 32'd5; B = 32'd5;
      end
    end
    start = 1'b0;
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_busy_gaps", 64'(nlow), 64'd0);

    // Reset in the middle of a MULT aborts it without a load strobe
    @(negedge Clk);
    start = 1'b1; op = 2'b00; A = 32'd12345; B = 32'd678;
    @(negedge Clk);
    start = 1'b0;
    repeat (11) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(write_hi), 64'd0);
    check("abort_lo", 64'(write_lo), 64'd0);
    nld = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (ld_hi || ld_lo || done) nld++;
    end
    check("abort_no_ld", 64'(nld), 64'd0);
    run_op("after_abort", 2'b00, 32'd12345, 32'd678, 32'd0, 32'h007F_B6F6, LAT_MUL);

    // Back-to-back DIVU with start held across the first completion
    @(negedge Clk);
    start = 1'b1; op = 2'b11; A = 32'd1000; B = 32'd7;
    @(negedge Clk);
    A = 32'd50; B = 32'd6;
    wait_done("b2b_first", ok);
    t1 = cyc;
    if (ok) begin
      check("b2b1_hi", 64'(write_hi), 64'd6);
      check("b2b1_lo", 64'(write_lo), 64'd142);
    end
    @(negedge Clk);
    start = 1'b0;
    wait_done("b2b_second", ok);
    if (ok) begin
      check("b2b_spacing", 64'(cyc - t1), 64'd34);
      check("b2b2_hi", 64'(write_hi), 64'd2);
      check("b2b2_lo", 64'(write_lo), 64'd8);
    end

    repeat (5) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; Hi/Lo result width = WIDTH each.
REQ-002 Port Clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port Rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port start, input, 1, SHALL be the operation request, sampled only in IDLE.
REQ-005 Port op, input, 2, SHALL select 00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU.
REQ-006 Ports A and B, input, WIDTH each, SHALL be rs/rt operands, sampled with start.
REQ-007 Ports write_hi and write_lo, output, WIDTH each, SHALL carry the results to the Hi/Lo register file.
REQ-008 Ports ld_hi and ld_lo, output, 1 each, SHALL be one-cycle load strobes for Hi and Lo.
REQ-009 Port busy, output, 1, SHALL be high while an operation is in flight, including the DONE cycle.
REQ-010 Port done, output, 1, SHALL be a one-cycle completion pulse coincident with ld_hi/ld_lo.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when the iteration counter reaches 0, DONE->IDLE unconditionally.
REQ-012 start SHALL be ignored outside IDLE: no queueing and no operand capture.
REQ-013 On accept, the block SHALL latch op, sign flags and operand magnitudes, and load the counter with WIDTH-1.
REQ-014 MULT/MULTU SHALL perform radix-2 shift-add, one bit per RUN cycle, for WIDTH cycles; result {Hi,Lo} = full 2*WIDTH-bit product.
REQ-015 DIV/DIVU SHALL perform restoring division, one quotient bit per RUN cycle, for WIDTH cycles; Lo = quotient, Hi = remainder.
REQ-016 Signed ops SHALL operate on magnitudes, then negate: product if signs differ; quotient if signs differ; remainder takes the dividend's sign.
REQ-017 Divide by zero SHALL NOT be special-cased in timing; results SHALL be Lo = all ones and Hi = A for DIVU, and Lo = all ones and Hi = A for DIV.
REQ-018 DIV of 0x80000000 by 0xFFFFFFFF SHALL give Lo = 0x80000000 and Hi = 0.
REQ-019 Latency: with start sampled at edge T, ld_hi/ld_lo/done SHALL be high for exactly the cycle following edge T+WIDTH+1, i.e. 33 cycles after accept at WIDTH=32.
REQ-020 ld_hi and ld_lo SHALL always assert together, for one cycle only, in DONE.
REQ-021 write_hi/write_lo SHALL be valid in the DONE cycle and hold the last result until the next DONE.
REQ-022 A new start SHALL be accepted in the first IDLE cycle after DONE, so back-to-back ops have a throughput of WIDTH+2 cycles.

Reset
REQ-023 Rst SHALL force IDLE and clear busy, done, ld_hi, ld_lo, write_hi, write_lo, the counter and the datapath registers to 0 at the next edge.
REQ-024 Rst asserted mid-operation SHALL abort with no ld pulse, and Hi/Lo SHALL be left unmodified downstream.
REQ-025 Rst and start high together SHALL give priority to reset.

Configuration
REQ-026 With macro MDU_FAST_MULT_EN defined, MULT/MULTU SHALL use a single-cycle 2*WIDTH-bit multiplier and go IDLE->DONE directly, with ld pulses in the cycle after accept (latency 1).
REQ-027 Without MDU_FAST_MULT_EN, multiplies SHALL use the iterative path of REQ-014.
REQ-028 Divide behaviour and latency SHALL be identical with or without MDU_FAST_MULT_EN.

Verification
REQ-029 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, done 33 cycles after accept (1 cycle with MDU_FAST_MULT_EN).
REQ-030 MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-031 DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=100, after normal latency; DIVU A=100, B=7 -> Lo=14, Hi=2.
REQ-032 Start pulsed at cycles 5 and 10 of a DIV -> only the first is executed, one done pulse, busy continuously high.
REQ-033 Rst asserted at cycle 12 of a MULT -> next cycle busy=0 and outputs 0; no ld pulse at all; a subsequent start executes normally.
REQ-034 Two back-to-back DIVU issued on the first IDLE cycle -> done pulses exactly 34 cycles apart, each with correct results.
